// File: rtl/score_text_writer.sv
// score_text_writer: accumulates the player score and converts it to two ASCII
// digits with a sequential double-dabble engine. A one-cycle text_valid strobe
// hands the digit pair to the on-screen character buffer.
// Optional build macro: SCORE_HIGH_EN adds a high_score output that holds the
// best converted score since reset.
module score_text_writer #(
  parameter int MAX_SCORE = 99,
  parameter int POINTS_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                game_start,
  input  logic                game_enable,
  input  logic                hit,
  input  logic [POINTS_W-1:0] hit_points,
  output logic [6:0]          my_score,
  output logic [6:0]          ascii_tens,
  output logic [6:0]          ascii_ones,
  output logic                text_valid,
  output logic                busy
`ifdef SCORE_HIGH_EN
  ,
  output logic [6:0]          high_score
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       pending;
  logic [2:0] bit_cnt;
  logic [6:0] snap;
  logic [7:0] bcd;
  logic       score_evt;

  // Add with an 8-bit intermediate so the sum never wraps, then clamp.
  function automatic logic [6:0] sat_add(input logic [6:0] a,
                                         input logic [POINTS_W-1:0] p);
    logic [7:0] s;
    s = {1'b0, a} + 8'(p);
    if (s > 8'(MAX_SCORE)) sat_add = 7'(MAX_SCORE);
    else                   sat_add = s[6:0];
  endfunction

  // One double-dabble step: correct nibbles >= 5, then shift in the next bit.
  // The tens nibble never exceeds 4 before the final shift, so dropping its
  // top bit loses nothing.
  function automatic logic [7:0] bcd_step(input logic [7:0] b,
                                          input logic       bit_in);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    bcd_step = 8'({hi, lo, bit_in});
  endfunction

  assign score_evt = game_start | (hit & game_enable);

  // Score register: game_start wins over a simultaneous hit.
  always_ff @(posedge clk) begin
    if (rst)                       my_score <= '0;
    else if (game_start)           my_score <= '0;
    else if (hit && game_enable)   my_score <= sat_add(my_score, hit_points);
  end

  // Pending flag: any score event requests a conversion; IDLE consumes it.
  always_ff @(posedge clk) begin
    if (rst)               pending <= 1'b0;
    else if (score_evt)    pending <= 1'b1;
    else if (state == IDLE) pending <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic: IDLE -> SHIFT (7 cycles) -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd6) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy whenever a conversion is in flight.
  always_comb begin
    busy = (state != IDLE);
  end

  // Conversion datapath; always initialised on entry from IDLE, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && pending) begin
      snap    <= my_score;
      bcd     <= '0;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      bcd     <= bcd_step(bcd, snap[6]);
      snap    <= {snap[5:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Digit outputs and strobe: ASCII only changes together with text_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      text_valid <= 1'b0;
      ascii_tens <= 7'h30;
      ascii_ones <= 7'h30;
    end else begin
      text_valid <= (state == DONE);
      if (state == DONE) begin
        ascii_tens <= {3'b011, bcd[7:4]};
        ascii_ones <= {3'b011, bcd[3:0]};
      end
    end
  end

`ifdef SCORE_HIGH_EN
  logic [6:0] conv_val;

  // Unshifted copy of the converted score for the high-score compare.
  always_ff @(posedge clk) begin
    if (state == IDLE && pending) conv_val <= my_score;
  end

  // High score survives game_start; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)                                   high_score <= '0;
    else if (state == DONE && conv_val > high_score) high_score <= conv_val;
  end
`endif

endmodule

// File: tb/tb_score_text_writer.sv
// Testbench for score_text_writer: directed scenarios plus randomized traffic,
// all compared every cycle against a timeline reference model.
module tb_score_text_writer;
  localparam int MAX_SCORE = 99;
  localparam int POINTS_W  = 3;

  logic                clk = 1'b0;
  logic                rst, game_start, game_enable, hit;
  logic [POINTS_W-1:0] hit_points;
  logic [6:0]          my_score, ascii_tens, ascii_ones;
  logic                text_valid, busy;
`ifdef SCORE_HIGH_EN
  logic [6:0]          high_score;
`endif

  score_text_writer #(.MAX_SCORE(MAX_SCORE), .POINTS_W(POINTS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .game_start (game_start),
    .game_enable(game_enable),
    .hit        (hit),
    .hit_points (hit_points),
    .my_score   (my_score),
    .ascii_tens (ascii_tens),
    .ascii_ones (ascii_ones),
    .text_valid (text_valid),
    .busy       (busy)
`ifdef SCORE_HIGH_EN
    ,
    .high_score (high_score)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, tv_cyc = -1, tv_cnt = 0;

  // Reference model: score as an integer, conversion as a countdown of the
  // remaining busy cycles (7 shift + 1 done), digits via /10 and %10.
  int m_score, m_pend, m_timer, m_snap, m_tv, m_tens, m_ones, m_high;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_edge();
    int s;
    if (rst) begin
      m_score = 0; m_pend = 0; m_timer = 0; m_tv = 0;
      m_tens = 0; m_ones = 0; m_high = 0;
    end else begin
      m_tv = 0;
      if (m_timer == 1) begin
        m_tv = 1;
        m_tens = m_snap / 10;
        m_ones = m_snap % 10;
        if (m_snap > m_high) m_high = m_snap;
        m_timer = 0;
      end else if (m_timer > 1) begin
        m_timer--;
      end else if (m_pend != 0) begin
        m_snap = m_score;
        m_timer = 8;
        m_pend = 0;
      end
      if (game_start) begin
        m_score = 0; m_pend = 1;
      end else if (hit && game_enable) begin
        s = m_score + int'(hit_points);
        m_score = (s > MAX_SCORE) ? MAX_SCORE : s;
        m_pend = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic gs, input logic en,
                      input logic h, input int pts);
    rst = r; game_start = gs; game_enable = en; hit = h;
    hit_points = POINTS_W'(pts);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("my_score",   int'(my_score),   m_score);
    chk("text_valid", int'(text_valid), m_tv);
    chk("ascii_tens", int'(ascii_tens), 48 + m_tens);
    chk("ascii_ones", int'(ascii_ones), 48 + m_ones);
    chk("busy",       int'(busy),       (m_timer > 0) ? 1 : 0);
`ifdef SCORE_HIGH_EN
    chk("high_score", int'(high_score), m_high);
`endif
    if (text_valid) begin
      tv_cyc = cyc;
      tv_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic hits(input int n, input int pts);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, pts);
  endtask

  int c0, base;

  initial begin
    rst = 1'b1; game_start = 1'b0; game_enable = 1'b0; hit = 1'b0;
    hit_points = '0;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("rst_ascii_tens", int'(ascii_tens), 'h30);
    chk("rst_busy", int'(busy), 0);
    idle(3);
    chk("rst_no_strobe", tv_cnt, 0);

    // Single hit of 5: strobe exactly 10 cycles after the hit cycle
    c0 = cyc;
    step(1'b0, 1'b0, 1'b1, 1'b1, 5);
    chk("hit5_score", int'(my_score), 5);
    idle(14);
    chk("hit5_latency", tv_cyc - c0, 10);
    chk("hit5_ones", int'(ascii_ones), 'h35);

    // Saturation at 99, repeated hit still strobes
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    hits(13, 7);
    hits(1, 6);
    idle(12);
    hits(1, 7);
    idle(12);
    chk("sat_score", int'(my_score), 99);
    chk("sat_tens", int'(ascii_tens), 'h39);
    c0 = cyc; base = tv_cnt;
    hits(1, 7);
    idle(12);
    chk("sat_again_latency", tv_cyc - c0, 10);
    chk("sat_again_strobes", tv_cnt - base, 1);

    // Two hits four cycles apart from score 0
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(12);
    c0 = cyc; base = tv_cnt;
    hits(1, 4);
    idle(3);
    hits(1, 3);
    idle(20);
    chk("two_hit_strobes", tv_cnt - base, 2);
    chk("two_hit_last", tv_cyc - c0, 19);
    chk("two_hit_ones", int'(ascii_ones), 'h37);

    // game_start with a hit in the same cycle at 42, then a disabled hit
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    hits(6, 7);
    idle(12);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5);
    idle(12);
    chk("gs_over_hit", int'(my_score), 0);
    base = tv_cnt;
    step(1'b0, 1'b0, 1'b0, 1'b1, 5);
    idle(12);
    chk("disabled_hit_strobes", tv_cnt - base, 0);

    // Reset in the middle of a conversion
    c0 = cyc;
    hits(1, 3);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0);
    base = tv_cnt;
    idle(14);
    chk("rst_abort_strobes", tv_cnt - base, 0);

`ifdef SCORE_HIGH_EN
    hits(1, 6); hits(1, 6);
    idle(12);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    hits(1, 8);
    idle(12);
    chk("high_keep", int'(high_score), 12);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 7)));
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/score_text_writer.md
Name: score_text_writer

Overview:
- Producer side of the two-digit score display path: accumulates the player score and converts it to two ASCII digits.
- Converts with a sequential double-dabble engine.
- Issues a one-cycle load strobe with the digit pair for the on-screen character buffer.
- Sits between the hit-detection/game-control logic and the score drawing chain.

Parameters:
MAX_SCORE, 99, saturation ceiling of the score; legal range 1..99.
POINTS_W, 3, width of the per-hit point increment.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
game_start  input  1  one-cycle pulse; clears score to 0
game_enable  input  1  hits are counted only while high
hit  input  1  one-cycle pulse; one scored hit
hit_points  input  POINTS_W  points added for the hit (0 is legal, no change)
my_score  output  7  current binary score, registered
ascii_tens  output  7  ASCII tens digit of last converted score
ascii_ones  output  7  ASCII ones digit of last converted score
text_valid  output  1  one-cycle strobe: ascii_tens/ascii_ones just updated
busy  output  1  conversion in progress

Behaviour:
- Reset (sync, rst=1 at clock edge) values:
  - my_score=0, ascii_tens=ascii_ones=7'h30, text_valid=0, busy=0.
  - FSM=IDLE, pending=0.
- Reset mid-conversion aborts the conversion; no text_valid is issued.
- Score update, registered, visible the cycle after the event:
  - game_start=1: my_score<=0, pending<=1. Overrides a hit in the same cycle.
  - hit=1 and game_enable=1: my_score<=min(my_score+hit_points, MAX_SCORE). The sum uses an 8-bit intermediate so it never wraps. pending<=1 even if the value is unchanged (saturated or 0 points).
  - hit while game_enable=0: ignored, no pending.
- Conversion FSM (IDLE, SHIFT, DONE):
  - IDLE: if pending, snapshot my_score, clear the 8-bit BCD accumulator, bit counter=0, pending<=0, go to SHIFT.
  - SHIFT: exactly 7 cycles. Each cycle: add 3 to any BCD nibble >=5, then shift the snapshot MSB into the BCD. After the 7th cycle go to DONE.
  - DONE: ascii_tens<={3'b011,tens}, ascii_ones<={3'b011,ones}, text_valid<=1 for one cycle, go to IDLE.
- busy=1 in SHIFT and DONE, combinational from state.
- Latency: hit in cycle N (FSM idle, no pending):
  - my_score new in N+1.
  - busy high N+2..N+9.
  - text_valid high and new ASCII in N+10.
- Hit/game_start during a conversion:
  - my_score updates immediately.
  - The running conversion completes with its old snapshot and strobes.
  - pending then starts a new conversion from IDLE on the cycle after DONE.
  - Multiple events collapse into one pending conversion.
- Back-to-back strobes are never adjacent (minimum 9 cycles apart).
- ascii outputs only change together with text_valid.

Optional Feature:
SCORE_HIGH_EN
- Defined:
  - Adds output high_score[6:0], reset to 0.
  - On each DONE, high_score<=max(high_score, snapshot).
  - game_start does not clear high_score; only rst does.
- Undefined: no high_score port and no register; behaviour otherwise identical.

Test Plan:
- Reset, hold 5 cycles -> my_score=0, ascii="00" (0x30,0x30), text_valid never asserted, busy=0.
- game_enable=1, hit with hit_points=5 at cycle N -> my_score=5 at N+1, text_valid single pulse at N+10, ascii_tens=0x30, ascii_ones=0x35.
- Score 97, hit_points=7 -> my_score=99 (saturated), ascii 0x39/0x39; a further hit -> 99 again, second strobe still issued.
- hit at N, second hit (points 3) at N+4 from score 0 with first points 4:
  - first strobe at N+10 shows "04";
  - second strobe at N+19 shows "07";
  - no other strobes.
- game_start and hit in same cycle at score 42 -> my_score=0, strobe shows "00"; hit with game_enable=0 -> no score change, no strobe.
- rst pulsed at N+5 of a conversion -> no text_valid, outputs at reset values. With SCORE_HIGH_EN, scores 12 then game_start then 8 -> high_score=12.
